// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
//   master : pipeline side, drives ID/EX/MEM status, receives stall/flush controls
//   slave  : hazard controller, receives status, drives stall/flush controls and stall counter
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PERF_W = 16
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_mem_read_i;
    logic              ex_branch_taken_i;
    logic              mem_load_i;

    logic              pc_stall_o;
    logic              ifid_stall_o;
    logic              ifid_flush_o;
    logic              idex_stall_o;
    logic              idex_flush_o;
    logic              exmem_stall_o;
    logic              memwb_flush_o;
    logic [PERF_W-1:0] stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_mem_read_i, ex_branch_taken_i, mem_load_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
        input  idex_flush_o, exmem_stall_o, memwb_flush_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_mem_read_i, ex_branch_taken_i, mem_load_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
        output idex_flush_o, exmem_stall_o, memwb_flush_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage RV32I pipeline.
// Resolves data-SRAM load wait, taken-branch redirect (stretched IF/ID flush)
// and load-use hazards; counts PC-stall cycles in a saturating counter.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   hz    : hazard bus (slave) - ID/EX/MEM status in, stall/flush controls
//           and stall_cnt_o out. Controls are combinational (zero latency).
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned MEM_WAIT_CYCLES = 1,
    parameter int unsigned REDIRECT_FLUSH  = 2,
    parameter int unsigned PERF_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned WAIT_W  = (MEM_WAIT_CYCLES < 1) ? 1 : $clog2(MEM_WAIT_CYCLES + 1);
    localparam int unsigned REDIR_W = $clog2(REDIRECT_FLUSH + 1);

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_WAIT_CYCLES);
    localparam logic [REDIR_W-1:0] REDIR_LOAD = REDIR_W'(REDIRECT_FLUSH - 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    logic [0:0]         state_q,     state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [REDIR_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic branch;
    logic load_use;

    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
    logic idex_flush_c, exmem_stall_c, memwb_flush_c;

    // Hazard detection
    assign mem_stall = hz.mem_load_i && (wait_cnt_q < WAIT_MAX);
    assign branch    = hz.ex_branch_taken_i && !mem_stall;
    assign load_use  = hz.ex_mem_read_i && (hz.ex_rd_i != '0) &&
                       ((hz.id_rs1_used_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                        (hz.id_rs2_used_i && (hz.id_rs2_i == hz.ex_rd_i)));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and stall/flush controls, priority MEM_WAIT > BRANCH > REDIRECT/LOADUSE
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        redir_cnt_d   = redir_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_stall_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_stall_c = 1'b0;
        memwb_flush_c = 1'b0;

        if (mem_stall) begin
            // Freeze the front of the pipe and bubble WB until the SRAM data lands
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            memwb_flush_c = 1'b1;
            wait_cnt_d    = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = '0;
            if (branch) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                redir_cnt_d  = REDIR_LOAD;
                state_d      = (REDIR_LOAD != '0) ? ST_REDIRECT : ST_RUN;
            end else if (state_q == ST_REDIRECT) begin
                // Wrong-path fetches still emerging from the instruction SRAM
                ifid_flush_c = 1'b1;
                redir_cnt_d  = redir_cnt_q - REDIR_W'(1);
                if (redir_cnt_q == REDIR_W'(1)) begin
                    state_d = ST_RUN;
                end
            end else if (load_use) begin
                pc_stall_c   = 1'b1;
                ifid_stall_c = 1'b1;
                idex_flush_c = 1'b1;
            end
        end

        if (pc_stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end

        // Controls are combinational, so reset must mask them directly
        if (rst_i) begin
            pc_stall_c    = 1'b0;
            ifid_stall_c  = 1'b0;
            ifid_flush_c  = 1'b0;
            idex_stall_c  = 1'b0;
            idex_flush_c  = 1'b0;
            exmem_stall_c = 1'b0;
            memwb_flush_c = 1'b0;
        end
    end

    assign hz.pc_stall_o    = pc_stall_c;
    assign hz.ifid_stall_o  = ifid_stall_c;
    assign hz.ifid_flush_o  = ifid_flush_c;
    assign hz.idex_stall_o  = idex_stall_c;
    assign hz.idex_flush_o  = idex_flush_c;
    assign hz.exmem_stall_o = exmem_stall_c;
    assign hz.memwb_flush_o = memwb_flush_c;
    assign hz.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random stimulus, compared each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned MWC    = 1;
    localparam int unsigned RF     = 2;
    localparam int unsigned PERF_W = 8;
    localparam int          SAT    = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .MEM_WAIT_CYCLES(MWC),
        .REDIRECT_FLUSH(RF), .PERF_W(PERF_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .hz   (hz)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles the current load has been held, flush-only cycles still owed, stall total
    int m_held   = 0;
    int m_redir  = 0;
    int m_stalls = 0;
    bit m_ms, m_br, m_pc;

    task automatic set_in(input logic ld, input logic br, input logic mr,
                          input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                          input logic [REG_AW-1:0] rs2, input logic u1, input logic u2);
        hz.mem_load_i        = ld;
        hz.ex_branch_taken_i = br;
        hz.ex_mem_read_i     = mr;
        hz.ex_rd_i           = rd;
        hz.id_rs1_i          = rs1;
        hz.id_rs2_i          = rs2;
        hz.id_rs1_used_i     = u1;
        hz.id_rs2_used_i     = u2;
    endtask

    // Compare current DUT outputs with the model (no time advance beyond settling)
    task automatic check(input string tag);
        logic [6:0] exp_o, got_o;
        logic [PERF_W-1:0] exp_cnt;
        bit hazard;
        #1;
        if (rst) begin
            m_held = 0; m_redir = 0; m_stalls = 0;
            m_ms = 0; m_br = 0; m_pc = 0;
            exp_o = '0;
        end else begin
            hazard = hz.ex_mem_read_i && (hz.ex_rd_i != 0) &&
                     ((hz.id_rs1_used_i && hz.id_rs1_i == hz.ex_rd_i) ||
                      (hz.id_rs2_used_i && hz.id_rs2_i == hz.ex_rd_i));
            m_ms = hz.mem_load_i && (m_held < int'(MWC));
            m_br = hz.ex_branch_taken_i && !m_ms;
            // bit order: pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush
            if (m_ms)              exp_o = 7'b1101011;
            else if (m_br)         exp_o = 7'b0010100;
            else if (m_redir > 0)  exp_o = 7'b0010000;
            else if (hazard)       exp_o = 7'b1100100;
            else                   exp_o = 7'b0000000;
            m_pc = exp_o[6];
        end
        exp_cnt = PERF_W'(m_stalls);
        got_o = {hz.pc_stall_o, hz.ifid_stall_o, hz.ifid_flush_o, hz.idex_stall_o,
                 hz.idex_flush_o, hz.exmem_stall_o, hz.memwb_flush_o};
        n_vec++;
        assert (got_o === exp_o) else begin
            n_err++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, got_o, exp_o);
        end
        n_vec++;
        assert (hz.stall_cnt_o === exp_cnt) else begin
            n_err++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, hz.stall_cnt_o, exp_cnt);
        end
    endtask

    // Check, advance the model across the coming rising edge, move to the next low phase
    task automatic step(input string tag);
        check(tag);
        if (!rst) begin
            m_held = m_ms ? m_held + 1 : 0;
            if (!m_ms) begin
                if (m_br)             m_redir = int'(RF) - 1;
                else if (m_redir > 0) m_redir--;
            end
            if (m_pc && m_stalls < SAT) m_stalls++;
        end
        @(negedge clk);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("idle");

        // Load wait
        set_in(1, 0, 0, 0, 0, 0, 0, 0); step("t1_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t1_done");
        step("t1_idle");

        // Load-use, then same registers with x0 destination
        set_in(0, 0, 1, 5, 5, 0, 1, 0); step("t2_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t2_clr");
        set_in(0, 0, 1, 0, 0, 0, 1, 0); step("t2_x0");
        set_in(0, 0, 1, 7, 3, 7, 0, 1); step("t2_rs2");
        set_in(0, 0, 1, 7, 3, 7, 1, 0); step("t2_rs2_unused");

        // Taken branch redirect
        set_in(0, 1, 0, 0, 0, 0, 0, 0); step("t3_c0");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t3_c1");
        step("t3_c2");

        // Branch coincident with load wait
        set_in(1, 1, 0, 0, 0, 0, 0, 0); step("t4_wait");
        set_in(0, 1, 0, 0, 0, 0, 0, 0); step("t4_br");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t4_redir");
        step("t4_idle");

        // Load-use ignored during redirect; branch reloads redirect
        set_in(0, 1, 0, 0, 0, 0, 0, 0); step("t5_br");
        set_in(0, 0, 1, 4, 4, 0, 1, 0); step("t5_lu_ignored");
        set_in(0, 1, 0, 0, 0, 0, 0, 0); step("t5_br0");
        set_in(0, 1, 0, 0, 0, 0, 0, 0); step("t5_reload");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t5_tail");
        step("t5_idle");

        // Reset pulsed while a load is being held
        set_in(1, 0, 0, 0, 0, 0, 0, 0); check("t6_pre");
        rst = 1'b1; step("t6_rst");
        rst = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0); step("t6_after");

        // Saturation: continuous load-use stall
        set_in(0, 0, 1, 1, 1, 0, 1, 0);
        for (int i = 0; i < SAT + 20; i++) step("sat");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step("sat_hold");

        // Random
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                   $urandom_range(0, 1) == 1,
                   REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                   REG_AW'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step("rand");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
